// File: rtl/sync_debouncer.sv
// Multi-channel input conditioner: per-channel synchronizer chain, counter debouncer
// with registered rise/fall pulses, plus a local reset synchronizer (async assert, sync release).
module sync_debouncer #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int RST_STAGES      = 2,
  parameter int CNT_W           = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             rst_out
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_r;
  logic [WIDTH-1:0]                  s_s;
  logic [WIDTH-1:0][CNT_W-1:0]       cnt_r;
  logic [WIDTH-1:0][CNT_W-1:0]       cnt_nxt_s;
  logic [WIDTH-1:0]                  level_nxt_s;
  logic [WIDTH-1:0]                  rise_nxt_s;
  logic [WIDTH-1:0]                  fall_nxt_s;
  logic [RST_STAGES-1:0]             rst_chain_r;

  assign s_s     = sync_r[SYNC_STAGES-1];
  assign rst_out = rst_chain_r[RST_STAGES-1];

  // Reset release chain: preset to 1, shifts in 0 so release is aligned to clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rst_chain_r <= {RST_STAGES{1'b1}};
    end else begin
      rst_chain_r <= {rst_chain_r[RST_STAGES-2:0], 1'b0};
    end
  end

  // Input synchronizer chain, shifts every clock regardless of tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r <= {(SYNC_STAGES*WIDTH){1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], din};
    end
  end

  // Debounce decision per channel; a sample matching the current level restarts the count.
  always_comb begin
    cnt_nxt_s   = cnt_r;
    level_nxt_s = level;
    rise_nxt_s  = {WIDTH{1'b0}};
    fall_nxt_s  = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      if (tick) begin
        if (s_s[i] == level[i]) begin
          cnt_nxt_s[i] = CNT_ZERO;
        end else if (cnt_r[i] == CNT_LAST) begin
          cnt_nxt_s[i]   = CNT_ZERO;
          level_nxt_s[i] = s_s[i];
          rise_nxt_s[i]  = s_s[i];
          fall_nxt_s[i]  = ~s_s[i];
        end else begin
          cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
        end
      end else begin
        cnt_nxt_s[i] = cnt_r[i];
      end
    end
  end

  // Debounce state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= {(WIDTH*CNT_W){1'b0}};
      level <= {WIDTH{1'b0}};
      rise  <= {WIDTH{1'b0}};
      fall  <= {WIDTH{1'b0}};
    end else begin
      cnt_r <= cnt_nxt_s;
      level <= level_nxt_s;
      rise  <= rise_nxt_s;
      fall  <= fall_nxt_s;
    end
  end

endmodule

// File: tb/tb_sync_debouncer.sv
// Scoreboard bench for sync_debouncer: stimulus queues expected pulse events,
// monitors pop and compare whenever a DUT emits a rise/fall pulse.
module tb_sync_debouncer;

  typedef struct {
    int         cyc;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] level;
  } event_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic [3:0] din;
  logic [3:0] level, rise, fall;
  logic       rst_out;

  logic       tick1;
  logic [3:0] din1;
  logic [3:0] level1, rise1, fall1;
  logic       rst_out1;

  int     cyc = 0;
  int     checks = 0;
  int     errors = 0;
  bit     tick_div4 = 1'b0;
  event_t exp_q[$];
  event_t exp1_q[$];

  sync_debouncer dut (
    .clk(clk), .reset(reset), .tick(tick), .din(din),
    .level(level), .rise(rise), .fall(fall), .rst_out(rst_out)
  );

  sync_debouncer #(.DEBOUNCE_CYCLES(1), .CNT_W(1)) dut1 (
    .clk(clk), .reset(reset), .tick(tick1), .din(din1),
    .level(level1), .rise(rise1), .fall(fall1), .rst_out(rst_out1)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(int c, logic [3:0] r, logic [3:0] f, logic [3:0] l);
    event_t e;
    e.cyc = c; e.rise = r; e.fall = f; e.level = l;
    exp_q.push_back(e);
  endtask

  task automatic push1(int c, logic [3:0] r, logic [3:0] f, logic [3:0] l);
    event_t e;
    e.cyc = c; e.rise = r; e.fall = f; e.level = l;
    exp1_q.push_back(e);
  endtask

  // Advance n falling edges; tick for the following rising edge is set here.
  task automatic step(int n);
    repeat (n) begin
      @(negedge clk);
      tick = tick_div4 ? (((cyc + 1) % 4) == 0) : 1'b1;
    end
  endtask

  task automatic compare_event(string tag, event_t e, logic [3:0] r, logic [3:0] f, logic [3:0] l);
    checks++;
    if (e.cyc != cyc || e.rise !== r || e.fall !== f || e.level !== l) begin
      errors++;
      $display("FAIL %s actual cyc %0d rise %h fall %h level %h required cyc %0d rise %h fall %h level %h",
               tag, cyc, r, f, l, e.cyc, e.rise, e.fall, e.level);
    end
  endtask

  // Monitor for the default-parameter instance.
  initial forever begin
    @(negedge clk);
    if (rise != 4'h0 || fall != 4'h0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse actual rise %h fall %h required none (cyc %0d)", rise, fall, cyc);
      end else begin
        compare_event("pulse", exp_q.pop_front(), rise, fall, level);
      end
    end
  end

  // Monitor for the single-sample instance.
  initial forever begin
    @(negedge clk);
    if (rise1 != 4'h0 || fall1 != 4'h0) begin
      if (exp1_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse1 actual rise %h fall %h required none (cyc %0d)", rise1, fall1, cyc);
      end else begin
        compare_event("pulse1", exp1_q.pop_front(), rise1, fall1, level1);
      end
    end
  end

  initial begin
    int e;
    int t1;
    int r;
    reset = 1'b1;
    tick  = 1'b1;
    tick1 = 1'b1;
    din   = 4'h0;
    din1  = 4'h0;

    // Reset state and reset synchronizer release.
    step(3);
    check("reset_level", {28'h0, level}, 32'h0);
    check("reset_rise_fall", {24'h0, rise, fall}, 32'h0);
    check("reset_rst_out", {31'h0, rst_out}, 32'h1);
    check("reset_level1", {28'h0, level1}, 32'h0);
    reset = 1'b0;
    step(1);
    check("rst_out_edge1", {31'h0, rst_out}, 32'h1);
    step(1);
    check("rst_out_edge2", {31'h0, rst_out}, 32'h0);
    step(38);
    check("idle_level", {28'h0, level}, 32'h0);

    // Single-sample debounce: a one-cycle input pulse passes with 3-edge latency.
    din1[0] = 1'b1;
    push1(cyc + 3, 4'h1, 4'h0, 4'h1);
    step(1);
    din1[0] = 1'b0;
    push1(cyc + 3, 4'h0, 4'h1, 4'h0);
    step(1);
    check("deb1_pre", {28'h0, level1}, 32'h0);
    step(1);
    check("deb1_up", {28'h0, level1}, 32'h1);
    step(1);
    check("deb1_down", {28'h0, level1}, 32'h0);
    step(5);

    // Clean rise on channel 0.
    din[0] = 1'b1;
    e = cyc;
    push(e + 18, 4'h1, 4'h0, 4'h1);
    step(17);
    check("t2_pre_accept", {28'h0, level}, 32'h0);
    step(1);
    check("t2_accept", {28'h0, level}, 32'h1);
    step(4);

    // Glitch on channel 1 restarts the count.
    din[1] = 1'b1;
    e = cyc;
    push(e + 29, 4'h2, 4'h0, 4'h3);
    step(10);
    din[1] = 1'b0;
    step(1);
    din[1] = 1'b1;
    step(7);
    check("t3_no_early_accept", {28'h0, level}, 32'h1);
    step(11);
    check("t3_late_accept", {28'h0, level}, 32'h3);
    step(3);

    // Tick every 4th clock on channel 2.
    tick_div4 = 1'b1;
    step(1);
    din[2] = 1'b1;
    e = cyc;
    t1 = ((e + 6) / 4) * 4;
    push(t1 + 60, 4'h4, 4'h0, 4'h7);
    step(t1 + 59 - e);
    check("t4_pre_accept", {28'h0, level}, 32'h3);
    step(1);
    check("t4_accept", {28'h0, level}, 32'h7);
    step(2);
    tick_div4 = 1'b0;
    step(3);

    // All channels high, then simultaneous fall.
    din[3] = 1'b1;
    e = cyc;
    push(e + 18, 4'h8, 4'h0, 4'hF);
    step(20);
    check("t5_all_high", {28'h0, level}, 32'hF);
    din = 4'h0;
    e = cyc;
    push(e + 18, 4'h0, 4'hF, 4'h0);
    step(18);
    check("t5_all_low", {28'h0, level}, 32'h0);
    step(2);

    // Reset mid-debounce of a falling transition, din[1] high at release.
    din[0] = 1'b1;
    e = cyc;
    push(e + 18, 4'h1, 4'h0, 4'h1);
    step(20);
    din[0] = 1'b0;
    step(12);
    #2;
    reset = 1'b1;
    din = 4'h2;
    #1;
    check("t6_async_level", {28'h0, level}, 32'h0);
    check("t6_async_rst_out", {31'h0, rst_out}, 32'h1);
    step(3);
    check("t6_hold_level", {28'h0, level}, 32'h0);
    reset = 1'b0;
    r = cyc;
    push(r + 18, 4'h2, 4'h0, 4'h2);
    step(1);
    check("t6_rst_out_edge1", {31'h0, rst_out}, 32'h1);
    step(1);
    check("t6_rst_out_edge2", {31'h0, rst_out}, 32'h0);
    step(16);
    check("t6_release_accept", {28'h0, level}, 32'h2);
    step(5);

    checks++;
    if (exp_q.size() != 0 || exp1_q.size() != 0) begin
      errors++;
      $display("FAIL missing_pulses actual pending %0d/%0d required 0/0", exp_q.size(), exp1_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
